// File: rtl/fft_reorder_if.sv
// Stream bus shared by the SDF stages and the reorder buffer:
// one enable plus a real/imag sample pair per cycle.
interface fft_reorder_if #(
  parameter int WIDTH = 16
);
  logic             data_en;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_i;

  modport master (
    output data_en,
    output data_r,
    output data_i
  );

  modport slave (
    input data_en,
    input data_r,
    input data_i
  );
endinterface

// File: rtl/fft_reorder.sv
// Output reorder buffer for the pipeline FFT.
// Frames arrive in bit-reversed order and are written into one of two
// ping-pong banks at the bit-reversed address, so that a linear read of a
// completed bank yields natural order. While one bank is read out, the next
// frame fills the other, letting back-to-back frames stream with no gap.
module fft_reorder #(
  parameter int N     = 64,
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset,
  fft_reorder_if.slave  ibus,
  fft_reorder_if.master obus
);

  localparam int              LOG_N = $clog2(N);
  localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  // Two banks of N complex samples; contents are never reset.
  logic [2*WIDTH-1:0] mem [0:1][0:N-1];

  logic [LOG_N-1:0] wcount;
  logic             wbank;
  logic [LOG_N-1:0] rcount;
  logic             rbank;
  logic [1:0]       full;
  state_t           state;

  logic             odata_en_q;
  logic [WIDTH-1:0] odata_r_q;
  logic [WIDTH-1:0] odata_i_q;

  logic             last_write;
  logic             last_read;
  logic [1:0]       set_full;
  logic [1:0]       clr_full;
  logic [1:0]       full_ahead;
  logic             next_rbank;

  // Reverse the LOG_N-bit index.
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
    logic [LOG_N-1:0] y;
    y = '0;
    for (int b = 0; b < LOG_N; b++) begin
      y[b] = x[LOG_N-1-b];
    end
    return y;
  endfunction

  assign last_write = ibus.data_en && (wcount == LAST);
  assign last_read  = (state == READ) && (rcount == LAST);
  assign next_rbank = ~rbank;

  // Per-bank set/clear strobes for the frame-complete flags.
  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (last_write) begin
      set_full[wbank] = 1'b1;
    end
    if (last_read) begin
      clr_full[rbank] = 1'b1;
    end
  end

  // Look-ahead flags let the reader start on the cycle the last sample lands.
  assign full_ahead = full | set_full;

  // Write-side counter and bank select; a gap in the enable aborts a partial frame.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wcount <= '0;
      wbank  <= 1'b0;
    end else if (ibus.data_en) begin
      wcount <= wcount + 1'b1;
      if (wcount == LAST) begin
        wbank <= ~wbank;
      end
    end else begin
      wcount <= '0;
    end
  end

  // Sample storage, written at the bit-reversed address of the arrival index.
  always_ff @(posedge clock) begin
    if (reset && ibus.data_en) begin
      mem[wbank][bitrev(wcount)] <= {ibus.data_r, ibus.data_i};
    end
  end

  // Frame-complete flags: writer sets, reader clears, each on its own bank.
  always_ff @(posedge clock) begin
    if (!reset) begin
      full <= '0;
    end else begin
      full <= (full & ~clr_full) | set_full;
    end
  end

  // Read FSM with registered output stream.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      rcount     <= '0;
      rbank      <= 1'b0;
      odata_en_q <= 1'b0;
      odata_r_q  <= '0;
      odata_i_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          odata_en_q <= 1'b0;
          rcount     <= '0;
          if (full_ahead[rbank]) begin
            state <= READ;
          end
        end
        READ: begin
          {odata_r_q, odata_i_q} <= mem[rbank][rcount];
          odata_en_q             <= 1'b1;
          rcount                 <= rcount + 1'b1;
          if (rcount == LAST) begin
            rbank <= next_rbank;
            if (!full_ahead[next_rbank]) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          odata_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign obus.data_en = odata_en_q;
  assign obus.data_r  = odata_r_q;
  assign obus.data_i  = odata_i_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for the FFT output reorder buffer (N=64 and N=16 instances).
module tb_fft_reorder;

  localparam int N  = 64;
  localparam int W  = 16;
  localparam int N2 = 16;
  localparam int W2 = 12;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fft_reorder_if #(.WIDTH(W))  ibus ();
  fft_reorder_if #(.WIDTH(W))  obus ();
  fft_reorder_if #(.WIDTH(W2)) ibus16 ();
  fft_reorder_if #(.WIDTH(W2)) obus16 ();

  fft_reorder #(.N(N), .WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .ibus  (ibus),
    .obus  (obus)
  );

  fft_reorder #(.N(N2), .WIDTH(W2)) dut16 (
    .clock (clock),
    .reset (reset),
    .ibus  (ibus16),
    .obus  (obus16)
  );

  typedef struct {
    int         cyc;
    logic [W-1:0] r;
    logic [W-1:0] i;
  } samp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  samp_t        outQ[$];
  logic [W2-1:0] q16[$];

  // Cycle index of the current clock period.
  always @(posedge clock) cyc <= cyc + 1;

  // Capture every valid output sample together with its cycle index.
  always @(negedge clock) begin
    samp_t s;
    if (obus.data_en === 1'b1) begin
      s.cyc = cyc;
      s.r   = obus.data_r;
      s.i   = obus.data_i;
      outQ.push_back(s);
    end
    if (obus16.data_en === 1'b1) begin
      q16.push_back(obus16.data_r);
    end
  end

  // A write must never land in a bank still holding an unread frame.
  always @(negedge clock) begin
    if (reset === 1'b1 && ibus.data_en === 1'b1) begin
      checkOutput("overrun", {31'b0, dut.full[dut.wbank]}, 32'd0);
    end
  end

  function automatic int bitrev(input int x, input int bits);
    int y;
    y = 0;
    for (int b = 0; b < bits; b++) begin
      if (x[b]) y = y | (1 << (bits - 1 - b));
    end
    return y;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic driveCycle(input bit en, input int r, input int i);
    @(posedge clock);
    #2;
    ibus.data_en = en;
    ibus.data_r  = r[W-1:0];
    ibus.data_i  = i[W-1:0];
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) driveCycle(1'b0, 0, 0);
  endtask

  task automatic applyStimulus(input int count, input int base, output int lastCyc);
    lastCyc = 0;
    for (int k = 0; k < count; k++) begin
      driveCycle(1'b1, base + k, -(base + k));
      lastCyc = cyc;
    end
  endtask

  task automatic drive16(input bit en, input int r);
    @(posedge clock);
    #2;
    ibus16.data_en = en;
    ibus16.data_r  = r[W2-1:0];
    ibus16.data_i  = r[W2-1:0];
  endtask

  // One full frame of N outputs starting at queue index idx.
  task automatic checkFrame(input string tag, input int idx, input int base, input int expFirst);
    logic [W-1:0] er;
    logic [W-1:0] ei;
    if (outQ.size() < idx + N) begin
      checkOutput({tag, "_avail"}, outQ.size(), idx + N);
      return;
    end
    checkOutput({tag, "_first_cyc"}, outQ[idx].cyc, expFirst);
    checkOutput({tag, "_last_cyc"}, outQ[idx+N-1].cyc, expFirst + N - 1);
    for (int j = 0; j < N; j++) begin
      er = W'(bitrev(j, 6) + base);
      ei = -er;
      checkOutput({tag, "_r"}, {16'b0, outQ[idx+j].r}, {16'b0, er});
      checkOutput({tag, "_i"}, {16'b0, outQ[idx+j].i}, {16'b0, ei});
    end
  endtask

  int last1, last2, lastA, scratch;
  int lasts[3];
  int exp6[6]   = '{0, 32, 16, 48, 8, 40};
  int exp16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  bit found;

  initial begin
    ibus.data_en   = 1'b0;
    ibus.data_r    = '0;
    ibus.data_i    = '0;
    ibus16.data_en = 1'b0;
    ibus16.data_r  = '0;
    ibus16.data_i  = '0;

    // Reset state
    repeat (4) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_en",   {31'b0, obus.data_en}, 32'd0);
    checkOutput("rst_r",    {16'b0, obus.data_r}, 32'd0);
    checkOutput("rst_i",    {16'b0, obus.data_i}, 32'd0);
    checkOutput("rst_en16", {31'b0, obus16.data_en}, 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    idle(2);

    // Single frame, r=k, i=-k
    $display("[TB] single frame");
    applyStimulus(N, 0, last1);
    idle(70);
    checkOutput("t1_count", outQ.size(), N);
    checkFrame("t1", 0, 0, last1 + 2);
    if (outQ.size() >= N) begin
      for (int m = 0; m < 6; m++) checkOutput("t1_spot", {16'b0, outQ[m].r}, exp6[m]);
      checkOutput("t1_spot_last", {16'b0, outQ[N-1].r}, 32'd63);
    end
    outQ.delete();

    // Back-to-back frames
    $display("[TB] back-to-back frames");
    applyStimulus(N, 0, last1);
    applyStimulus(N, 100, last2);
    idle(140);
    checkOutput("t2_count", outQ.size(), 2 * N);
    checkFrame("t2a", 0, 0, last1 + 2);
    checkFrame("t2b", N, 100, last1 + 2 + N);
    outQ.delete();

    // Aborted partial frame followed by a full frame
    $display("[TB] abort");
    applyStimulus(40, 500, scratch);
    idle(3);
    applyStimulus(N, 200, lastA);
    idle(70);
    checkOutput("t3_count", outQ.size(), N);
    checkFrame("t3", 0, 200, lastA + 2);
    outQ.delete();

    // Reset during readout at output index 20
    $display("[TB] reset mid-readout");
    applyStimulus(N, 300, last1);
    idle(1);
    found = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(negedge clock);
      if (obus.data_en === 1'b1 && obus.data_r === W'(bitrev(20, 6) + 300)) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("t4_found", {31'b0, found}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("t4_en", {31'b0, obus.data_en}, 32'd0);
    checkOutput("t4_r",  {16'b0, obus.data_r}, 32'd0);
    checkOutput("t4_i",  {16'b0, obus.data_i}, 32'd0);
    reset = 1'b1;
    idle(80);
    checkOutput("t4_no_more", outQ.size(), 21);
    outQ.delete();
    applyStimulus(N, 400, last1);
    idle(70);
    checkOutput("t4_count", outQ.size(), N);
    checkFrame("t4", 0, 400, last1 + 2);
    outQ.delete();

    // Three frames separated by 10 idle cycles
    $display("[TB] spaced frames");
    for (int f = 0; f < 3; f++) begin
      applyStimulus(N, 1000 * (f + 1), lasts[f]);
      idle(10);
    end
    idle(70);
    checkOutput("t5_count", outQ.size(), 3 * N);
    checkFrame("t5a", 0,     1000, lasts[0] + 2);
    checkFrame("t5b", N,     2000, lasts[1] + 2);
    checkFrame("t5c", 2 * N, 3000, lasts[2] + 2);
    outQ.delete();

    // N=16 instance with a ramp
    $display("[TB] N=16 ramp");
    for (int k = 0; k < N2; k++) drive16(1'b1, k);
    drive16(1'b0, 0);
    repeat (30) @(posedge clock);
    checkOutput("t6_count", q16.size(), N2);
    if (q16.size() >= N2) begin
      for (int j = 0; j < N2; j++) checkOutput("t6_r", {20'b0, q16[j]}, exp16[j]);
    end
    checkOutput("t6_no_64_out", outQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
Name: fft_reorder

Overview:
- Output reorder buffer that sits after the last radix-2^2 SDF stage of the pipeline FFT.
- The SDF chain emits each frame in bit-reversed index order. This block collects each frame and re-emits it in natural order.
- It uses two ping-pong banks, so back-to-back frames stream with no gap. Input and output use the same enable/real/imag stream format as the SDF stages.

Parameters:
- N, 64, number of FFT points per frame (power of 2, >=4); LOG_N = log2(N).
- WIDTH, 16, data bit length per real/imag component.

Ports:
- clock  input  1  master clock.
- reset  input  1  synchronous, active-low reset: sampled on the rising edge of clock, and reset=0 resets the block.
- idata_en  input  1  input data enable; high for N consecutive cycles per frame.
- idata_r  input  WIDTH  input data (real), bit-reversed order.
- idata_i  input  WIDTH  input data (imag), bit-reversed order.
- odata_en  output  1  output data enable; high for N consecutive cycles per frame.
- odata_r  output  WIDTH  output data (real), natural order.
- odata_i  output  WIDTH  output data (imag), natural order.

Behaviour:
- Storage: two banks, each N x 2*WIDTH. Memory has no reset.
- Reset (reset=0 at a clock edge) clears the following, effective the next cycle:
  - wcount, wbank, full[1:0], rcount, rbank, reading.
  - odata_en=0, odata_r=0, odata_i=0.
  - Any partial or pending frame is discarded.
- Write side:
  - On a cycle with idata_en=1: write {idata_r, idata_i} to bank[wbank] at address bitrev(wcount) over LOG_N bits, then increment wcount.
  - When the write with wcount==N-1 occurs: set full[wbank], toggle wbank, wrap wcount to 0.
- Abort: idata_en=0 while 0<wcount<N forces wcount to 0. The partial frame is discarded, full is not set, and wbank is unchanged.
- Read FSM, two states, IDLE and READ:
  - IDLE: if full[rbank]=1, go to READ with rcount=0.
  - READ, each cycle:
    - Read bank[rbank][rcount], registered into odata_r/odata_i.
    - odata_en is registered high in the same cycle as the data.
    - Increment rcount.
  - At rcount==N-1: clear full[rbank] and toggle rbank. If full of the new rbank is already set, stay in READ with rcount=0 (seamless). Otherwise go to IDLE.
- Latency: the last input sample of a frame is accepted in cycle t. The read of address 0 happens in cycle t+1. odata_en=1 with output index 0 appears in cycle t+2 and stays high through t+N+1.
- Ordering: output index j equals input sample number bitrev(j) of that frame.
- Set and clear in the same cycle: if the write side sets full[b] in the same cycle the reader clears full[b'] with b' != b, both take effect. Same-bank set and clear cannot occur given the contiguous-frame input protocol.
- Overrun: cannot happen with compliant input, since frames are >=N cycles apart and a read takes exactly N cycles. Verification asserts that a write never targets a bank with full=1.
- Idle data: when odata_en=0, odata_r/odata_i hold their last value.

Test Plan:
- N=64, one frame with input sample k carrying r=k, i=-k. Required: odata_en high for 64 cycles starting 2 cycles after the last input. Output r sequence is 0,32,16,48,8,40,...,63; each i equals -r.
- Two back-to-back frames (128 consecutive idata_en cycles, frame 2 values offset by +100). Required: odata_en high for 128 contiguous cycles with no gap. The second 64 outputs are bitrev(j)+100.
- Abort: 40 samples, 3 idle cycles, then a full 64-sample frame. Required: exactly one output frame, whose content comes from the 64-sample frame only.
- Reset mid-readout: hold reset=0 at output index 20, then release. Required: odata_en=0 and odata=0 the cycle after. No further output until a new full frame arrives, which is then output correctly.
- Frames separated by 10 idle cycles, 3 frames. Required: 3 output frames of 64, each starting 2 cycles after its frame's last input.
- Parameter N=16, WIDTH=12, ramp input. Required: output 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
